// File: rtl/zoom_ctrl.sv
// zoom_ctrl: 2x nearest-neighbour zoom sequencer.
// For each source row, the block reads largura pixels into row_out. The
// external datapath returns the horizontally doubled row on row_in. The block
// then writes that row twice into the destination image, which is 2*largura
// wide and 2*altura high.
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous active-high reset
//   start      one-cycle frame request; only accepted in IDLE
//   busy       high while reading or writing rows
//   done       one-cycle pulse at frame completion
//   src_addr   source read address; data arrives on src_rdata one cycle later
//   src_rdata  source pixel data
//   row_out    assembled source row, pixel c at [c*8 +: 8]
//   row_in     replicated row from the datapath, 2*largura pixels
//   dst_addr   destination write address (0 when not writing)
//   dst_wdata  destination write data (0 when not writing)
//   dst_we     destination write enable
module zoom_ctrl #(
  parameter int unsigned largura = 320,
  parameter int unsigned altura  = 240,
  parameter int unsigned SRC_AW  = 17,
  parameter int unsigned DST_AW  = 19
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [SRC_AW-1:0]         src_addr,
  input  logic [7:0]                src_rdata,
  output logic [largura*8-1:0]      row_out,
  input  logic [2*largura*8-1:0]    row_in,
  output logic [DST_AW-1:0]         dst_addr,
  output logic [7:0]                dst_wdata,
  output logic                      dst_we
);

  // Counter widths: c spans 0..largura, x spans 0..2*largura-1, r spans 0..altura-1
  localparam int unsigned CW = $clog2(largura + 1);
  localparam int unsigned XW = $clog2(2 * largura);
  localparam int unsigned RW = (altura > 1) ? $clog2(altura) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            st, nxt_st;
  logic [RW-1:0]     r, nxt_r;
  logic [CW-1:0]     c, nxt_c;
  logic              s, nxt_s;
  logic [XW-1:0]     x, nxt_x;
  // Running read/write addresses. Rows are stored back to back, so both
  // addresses advance by one per access and need no multiplier.
  logic [SRC_AW-1:0] ra, nxt_ra;
  logic [DST_AW-1:0] wa, nxt_wa;

  logic last_row;
  logic last_px;
  logic x_wrap;

  assign last_row = (r == RW'(altura - 1));
  assign last_px  = (c == CW'(largura - 1));
  assign x_wrap   = (x == XW'(2 * largura - 1));

  // Next-state and counter logic
  always_comb begin
    nxt_st = st;
    nxt_r  = r;
    nxt_c  = c;
    nxt_s  = s;
    nxt_x  = x;
    nxt_ra = ra;
    nxt_wa = wa;
    case (st)
      IDLE: begin
        if (start) begin
          nxt_st = READ;
          nxt_r  = '0;
          nxt_c  = '0;
          nxt_ra = '0;
          nxt_wa = '0;
        end
      end
      READ: begin
        if (c == CW'(largura)) begin
          // Extra cycle lets the last pixel's data land in row_out
          nxt_st = WRITE;
          nxt_s  = 1'b0;
          nxt_x  = '0;
        end else begin
          nxt_c = c + CW'(1);
          // Stop at the last source pixel so ra never exceeds largura*altura-1
          if (!(last_px && last_row)) begin
            nxt_ra = ra + SRC_AW'(1);
          end
        end
      end
      WRITE: begin
        // Stop at the last destination pixel so wa never exceeds its range
        if (!(s && x_wrap && last_row)) begin
          nxt_wa = wa + DST_AW'(1);
        end
        if (x_wrap) begin
          nxt_x = '0;
          if (s) begin
            if (last_row) begin
              nxt_st = DONE;
            end else begin
              nxt_st = READ;
              nxt_r  = r + RW'(1);
              nxt_c  = '0;
            end
          end else begin
            nxt_s = 1'b1;
          end
        end else begin
          nxt_x = x + XW'(1);
        end
      end
      DONE: begin
        nxt_st = IDLE;
      end
      default: begin
        nxt_st = IDLE;
      end
    endcase
  end

  // State, counters, row buffer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= IDLE;
      r        <= '0;
      c        <= '0;
      s        <= 1'b0;
      x        <= '0;
      ra       <= '0;
      wa       <= '0;
      row_out  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dst_we   <= 1'b0;
      src_addr <= '0;
      dst_addr <= '0;
    end else begin
      st     <= nxt_st;
      r      <= nxt_r;
      c      <= nxt_c;
      s      <= nxt_s;
      x      <= nxt_x;
      ra     <= nxt_ra;
      wa     <= nxt_wa;
      busy   <= (nxt_st == READ) || (nxt_st == WRITE);
      done   <= (nxt_st == DONE);
      dst_we <= (nxt_st == WRITE);
      // The address is driven only on the largura address cycles of READ
      src_addr <= ((nxt_st == READ) && (nxt_c != CW'(largura))) ? nxt_ra : '0;
      dst_addr <= (nxt_st == WRITE) ? nxt_wa : '0;
      // The byte fetched on READ cycle c-1 arrives during cycle c
      if ((st == READ) && (c != '0)) begin
        row_out[(32'(c) - 32'd1) * 32'd8 +: 8] <= src_rdata;
      end
    end
  end

  // row_in is a combinational function of row_out, so write data is muxed live
  assign dst_wdata = dst_we ? row_in[32'(x) * 32'd8 +: 8] : 8'h00;

endmodule

// File: tb/tb_zoom_ctrl.sv
module tb_zoom_ctrl;

  localparam int L   = 4;
  localparam int A   = 2;
  localparam int SAW = 3;
  localparam int DAW = 5;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               busy;
  logic               done;
  logic [SAW-1:0]     src_addr;
  logic [7:0]         src_rdata;
  logic [L*8-1:0]     row_out;
  logic [2*L*8-1:0]   row_in;
  logic [DAW-1:0]     dst_addr;
  logic [7:0]         dst_wdata;
  logic               dst_we;

  int checks = 0;
  int errors = 0;

  int wr_total   = 0;
  int done_total = 0;
  int overlap    = 0;
  int idle_bad   = 0;

  byte unsigned exp_px [32] = '{
    8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4,
    8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4,
    8'd5, 8'd5, 8'd6, 8'd6, 8'd7, 8'd7, 8'd8, 8'd8,
    8'd5, 8'd5, 8'd6, 8'd6, 8'd7, 8'd7, 8'd8, 8'd8
  };

  zoom_ctrl #(
    .largura (L),
    .altura  (A),
    .SRC_AW  (SAW),
    .DST_AW  (DAW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .src_addr  (src_addr),
    .src_rdata (src_rdata),
    .row_out   (row_out),
    .row_in    (row_in),
    .dst_addr  (dst_addr),
    .dst_wdata (dst_wdata),
    .dst_we    (dst_we)
  );

  always #5 clk = ~clk;

  // Source memory: pixel n holds n+1, one-cycle read latency
  initial src_rdata = 8'h00;
  always @(posedge clk) src_rdata <= 8'(src_addr) + 8'd1;

  // Replication datapath: output pixel p is source pixel p/2
  for (genvar p = 0; p < 2 * L; p++) begin : g_rep
    assign row_in[p*8 +: 8] = row_out[(p/2)*8 +: 8];
  end

  always @(posedge clk) begin
    if (dst_we) wr_total <= wr_total + 1;
    if (done) done_total <= done_total + 1;
    if (busy && done) overlap <= overlap + 1;
    if (!dst_we && (dst_addr != '0 || dst_wdata != 8'h00)) idle_bad <= idle_bad + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++;
    if (dst_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", dst_we); end
    checks++;
    if (src_addr !== '0) begin errors++; $display("FAIL reset_src_addr got %0d exp 0", src_addr); end
    checks++;
    if (dst_addr !== '0 || dst_wdata !== 8'h00) begin
      errors++; $display("FAIL reset_dst got addr %0d data %0d exp 0 0", dst_addr, dst_wdata);
    end
    checks++;
    if (row_out !== '0) begin errors++; $display("FAIL reset_row_out got %h exp 0", row_out); end
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy got %b exp 0", busy); end
  endtask

  task automatic test_frame(input string tag);
    logic [7:0] got [32];
    int nb;
    int nw;
    int rr;
    int j;
    int w;
    nb = 0;
    nw = 0;
    for (int k = 0; k < 32; k++) got[k] = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy !== 1'b1) break;
      rr = i / 21;
      j  = i % 21;
      if (j < 4) begin
        checks++;
        if (src_addr !== SAW'(rr * 4 + j)) begin
          errors++; $display("FAIL %s src_addr cyc %0d got %0d exp %0d", tag, i, src_addr, rr * 4 + j);
        end
      end
      if (j >= 5) begin
        w = j - 5;
        checks++;
        if (dst_we !== 1'b1 || dst_addr !== DAW'(rr * 16 + w) ||
            dst_wdata !== 8'(rr * 4 + (w % 8) / 2 + 1)) begin
          errors++;
          $display("FAIL %s write cyc %0d got we %b addr %0d data %0d exp we 1 addr %0d data %0d",
                   tag, i, dst_we, dst_addr, dst_wdata, rr * 16 + w, rr * 4 + (w % 8) / 2 + 1);
        end
        if (dst_we === 1'b1) begin
          got[dst_addr] = dst_wdata;
          nw++;
        end
      end else begin
        checks++;
        if (dst_we !== 1'b0 || dst_addr !== '0 || dst_wdata !== 8'h00) begin
          errors++;
          $display("FAIL %s read_nowrite cyc %0d got we %b addr %0d data %0d exp 0 0 0",
                   tag, i, dst_we, dst_addr, dst_wdata);
        end
      end
      nb++;
      tick();
    end
    checks++;
    if (nb != 42) begin errors++; $display("FAIL %s busy_cycles got %0d exp 42", tag, nb); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL %s done_pulse got done %b busy %b exp 1 0", tag, done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL %s done_width got %b exp 0", tag, done); end
    checks++;
    if (nw != 32) begin errors++; $display("FAIL %s write_count got %0d exp 32", tag, nw); end
    for (int k = 0; k < 32; k++) begin
      checks++;
      if (got[k] !== exp_px[k]) begin
        errors++; $display("FAIL %s dst_pixel %0d got %0d exp %0d", tag, k, got[k], exp_px[k]);
      end
    end
    checks++;
    if (row_out !== 32'h08070605) begin
      errors++; $display("FAIL %s row_out got %h exp 08070605", tag, row_out);
    end
  endtask

  task automatic test_start_ignored();
    int w0;
    int d0;
    int nb;
    w0 = wr_total;
    d0 = done_total;
    nb = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (busy !== 1'b1) break;
      start = (i == 10);
      nb++;
      tick();
    end
    start = 1'b0;
    repeat (5) tick();
    checks++;
    if (nb != 42) begin errors++; $display("FAIL restart_busy_cycles got %0d exp 42", nb); end
    checks++;
    if (wr_total - w0 != 32) begin errors++; $display("FAIL restart_writes got %0d exp 32", wr_total - w0); end
    checks++;
    if (done_total - d0 != 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", done_total - d0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL restart_no_queue busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    int w1;
    int d0;
    d0 = done_total;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_precond busy got %b exp 1", busy); end
    reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || dst_we !== 1'b0 || done !== 1'b0 || dst_addr !== '0) begin
      errors++;
      $display("FAIL abort_outputs got busy %b we %b done %b addr %0d exp 0 0 0 0",
               busy, dst_we, done, dst_addr);
    end
    reset = 1'b0;
    w1 = wr_total;
    repeat (10) tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle busy got %b exp 0", busy); end
    checks++;
    if (wr_total != w1) begin errors++; $display("FAIL abort_writes got %0d exp %0d", wr_total, w1); end
    checks++;
    if (done_total != d0) begin errors++; $display("FAIL abort_done got %0d exp %0d", done_total, d0); end
  endtask

  task automatic test_start_reset();
    reset = 1'b1;
    start = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || src_addr !== '0) begin
      errors++; $display("FAIL start_reset_same got busy %b src %0d exp 0 0", busy, src_addr);
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL start_reset_after got busy %b done %b exp 0 0", busy, done);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL busy_done_overlap got %0d exp 0", overlap); end
    checks++;
    if (idle_bad != 0) begin errors++; $display("FAIL idle_dst_nonzero got %0d exp 0", idle_bad); end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    test_reset();
    test_frame("frame1");
    test_start_ignored();
    test_reset_mid();
    test_frame("after_abort");
    test_start_reset();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
